// File: rtl/vector_alu_sequencer_if.sv
// Instruction and result handshake bundle for the vector ALU sequencer.
// The master side issues instructions and consumes results; the slave
// side is the sequencer itself.
interface vector_alu_sequencer_if #(
    parameter int NUM_ELEM = 8,
    parameter int ELEM_W   = 32
);
    logic                       in_valid;
    logic                       in_ready;
    logic [2:0]                 in_op;
    logic [3:0]                 in_vl;
    logic [NUM_ELEM*ELEM_W-1:0] in_va;
    logic [NUM_ELEM*ELEM_W-1:0] in_vb;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_ELEM*ELEM_W-1:0] out_vd;
    logic [3:0]                 out_vl;

    modport master (
        output in_valid, in_op, in_vl, in_va, in_vb, out_ready,
        input  in_ready, out_valid, out_vd, out_vl
    );

    modport slave (
        input  in_valid, in_op, in_vl, in_va, in_vb, out_ready,
        output in_ready, out_valid, out_vd, out_vl
    );
endinterface

// File: rtl/vector_alu_sequencer.sv
// Vector ALU sequencer: accepts one vector instruction, streams its elements
// one per cycle through an external combinational ALU, collects the results
// into a buffer and presents the whole vector until the consumer takes it.
module vector_alu_sequencer #(
    parameter int NUM_ELEM = 8,
    parameter int ELEM_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vector_alu_sequencer_if.slave bus,
    output logic                 alu_ena,
    output logic [ELEM_W-1:0]    alu_a,
    output logic [ELEM_W-1:0]    alu_b,
    output logic [2:0]           alu_sel,
    input  logic [ELEM_W-1:0]    alu_result
);

    localparam int VEC_W = NUM_ELEM * ELEM_W;
    // in_vl is only 4 bits, so the usable length never exceeds 15.
    localparam int         MAX_VL_I = (NUM_ELEM > 15) ? 15 : NUM_ELEM;
    localparam logic [3:0] MAX_VL   = 4'(MAX_VL_I);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          idx;
    logic [3:0]          vl_q;
    logic [2:0]          op_q;
    logic [VEC_W-1:0]    va_q;
    logic [VEC_W-1:0]    vb_q;
    logic [ELEM_W-1:0]   res [NUM_ELEM];
    logic                accept;
    logic                last_elem;
    logic [3:0]          vl_eff;

    assign accept    = bus.in_valid && (state == IDLE);
    assign vl_eff    = (bus.in_vl > MAX_VL) ? MAX_VL : bus.in_vl;
    // Only meaningful in EXEC, where vl_q is at least 1.
    assign last_elem = (idx == (vl_q - 4'd1));

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: zero-length vectors skip EXEC entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (vl_eff == 4'd0) ? DONE : EXEC;
                end
            end
            EXEC: begin
                if (last_elem) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Instruction control: element index, latched op and effective length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= 4'd0;
            op_q <= 3'd0;
            vl_q <= 4'd0;
        end else if (accept) begin
            idx  <= 4'd0;
            op_q <= bus.in_op;
            vl_q <= vl_eff;
        end else if (state == EXEC) begin
            idx  <= idx + 4'd1;
        end
    end

    // Source operands are captured once so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (accept) begin
            va_q <= bus.in_va;
            vb_q <= bus.in_vb;
        end
    end

    // Result buffer: cleared on accept, one slot written per EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                res[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                res[i] <= '0;
            end
        end else if (state == EXEC) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                if (idx == 4'(i)) begin
                    res[i] <= alu_result;
                end
            end
        end
    end

    // ALU drive: element idx of the latched operands, quiet outside EXEC.
    always_comb begin
        alu_ena = 1'b0;
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = 3'd0;
        if (state == EXEC) begin
            alu_ena = 1'b1;
            alu_sel = op_q;
            for (int i = 0; i < NUM_ELEM; i++) begin
                if (idx == 4'(i)) begin
                    alu_a = va_q[i*ELEM_W +: ELEM_W];
                    alu_b = vb_q[i*ELEM_W +: ELEM_W];
                end
            end
        end
    end

    // Handshake and result presentation, all decoded from registered state.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.out_vl    = vl_q;
        bus.out_vd    = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            bus.out_vd[i*ELEM_W +: ELEM_W] = res[i];
        end
    end

endmodule

// File: doc/vector_alu_sequencer.md
VECTOR_ALU_SEQUENCER -- requirements
Module: vector_alu_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_ELEM, default 8, the maximum elements per vector.
REQ-002 The block SHALL have parameter ELEM_W, default 32, the element width in bits.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: a vector instruction is offered.
REQ-007 Port in_ready, output, 1: the block accepts the instruction this cycle.
REQ-008 Port in_op, input, 3: ALU select code; 0 add, 1 sub, 2 mul, 3 constant 254, 4-7 zero.
REQ-009 Port in_vl, input, 4: vector length, in elements.
REQ-010 Port in_va, input, NUM_ELEM*ELEM_W: source vector A; element i is bits [i*ELEM_W +: ELEM_W].
REQ-011 Port in_vb, input, NUM_ELEM*ELEM_W: source vector B, same packing as in_va.
REQ-012 Port alu_ena, output, 1: enable to the downstream vector ALU.
REQ-013 Port alu_a, output, ELEM_W: operand A to the ALU.
REQ-014 Port alu_b, output, ELEM_W: operand B to the ALU.
REQ-015 Port alu_sel, output, 3: operation select to the ALU.
REQ-016 Port alu_result, input, ELEM_W: combinational result returned by the ALU.
REQ-017 Port out_valid, output, 1: a result vector is available.
REQ-018 Port out_ready, input, 1: the consumer accepts the result vector.
REQ-019 Port out_vd, output, NUM_ELEM*ELEM_W: result vector, same packing as in_va.
REQ-020 Port out_vl, output, 4: effective vector length of the result.

Function
REQ-021 The FSM SHALL have exactly three states, IDLE, EXEC and DONE, and SHALL hold no other control state.
REQ-022 in_ready SHALL be 1 only in IDLE.
REQ-023 An instruction SHALL be accepted only on a rising edge where in_valid and in_ready are both 1.
REQ-024 On accept, the block SHALL latch in_op, in_va and in_vb, and compute the effective length vl_eff = min(in_vl, NUM_ELEM).
REQ-025 On accept, the block SHALL clear the result buffer to zero and set the element index to 0.
REQ-026 On accept with vl_eff = 0, the FSM SHALL go IDLE -> DONE; otherwise it SHALL go IDLE -> EXEC.
REQ-027 In EXEC at index i, alu_ena SHALL be 1, alu_a = A[i], alu_b = B[i], and alu_sel = latched op.
REQ-028 In EXEC, alu_result SHALL be written into result slot i at the clock edge.
REQ-029 In EXEC, the index SHALL increment by one per cycle.
REQ-030 EXEC SHALL go to DONE on the edge that writes slot vl_eff-1; EXEC SHALL last exactly vl_eff cycles.
REQ-031 Outside EXEC, alu_ena, alu_a, alu_b and alu_sel SHALL all be 0.
REQ-032 Result slots at or above vl_eff SHALL read 0.
REQ-033 out_valid SHALL be 1 only in DONE; out_vd and out_vl SHALL be held stable while out_valid is 1.
REQ-034 Latency: for an accept at edge T, out_valid SHALL rise after edge T+vl_eff (vl_eff=0 gives 1 cycle).
REQ-035 DONE SHALL go to IDLE on an edge where out_ready is 1; otherwise DONE SHALL hold.
REQ-036 No instruction SHALL be accepted in the same cycle a result is released, because in_ready is 0 in DONE.
REQ-037 Arithmetic SHALL be performed entirely by the ALU; results SHALL be stored truncated to ELEM_W with no carry or overflow kept.
REQ-038 Op codes 4-7 SHALL be passed to the ALU unchanged, and the block SHALL store whatever the ALU returns.
REQ-039 in_valid, in_op, in_vl, in_va and in_vb SHALL be ignored outside IDLE.
REQ-040 A change to in_va or in_vb after accept SHALL NOT affect the result.

Reset
REQ-041 When rst_n is 0, the block SHALL immediately (asynchronously) enter IDLE.
REQ-042 On reset, the index, latched op, result buffer and out_vl SHALL all be 0.
REQ-043 During and after reset: in_ready = 1, out_valid = 0, alu_ena = 0, out_vd = 0.
REQ-044 Reset asserted in EXEC or DONE SHALL abort the instruction; the partial result SHALL be discarded and SHALL NOT be presented.

Verification
REQ-045 Add test: op=0, vl=4, A[i]=i+1, B[i]=10 -> out_vd = {11,12,13,14,0,0,0,0}, out_vl=4, out_valid rises 4 cycles after accept.
REQ-046 Sub wrap test: op=1, vl=1, A[0]=0, B[0]=1 -> slot0 = 32'hFFFF_FFFF; op=2, A[0]=32'h10000, B[0]=32'h10000 -> slot0 = 0.
REQ-047 Clamp/zero-length test: vl=15 -> out_vl=8 and EXEC lasts 8 cycles; vl=0 -> out_valid 1 cycle after accept, out_vd = 0, alu_ena never 1.
REQ-048 Backpressure test: out_ready=0 for 5 cycles in DONE -> out_valid and out_vd stay stable, in_ready=0, and a new in_valid is ignored; out_ready=1 -> IDLE next cycle.
REQ-049 Reset test: rst_n driven low during EXEC at index 2 -> out_valid=0 and in_ready=1 immediately; the next instruction (op=3, vl=2) -> {254,254,0,...}.
REQ-050 Op-code and input-change test: op=5 -> all slots 0; in_va changed during EXEC -> result unchanged.
